// File: rtl/prince_byte_stream.sv
// Byte-serial PRINCE front end: framed byte input (header, optional key, text),
// one-cycle combinational cipher evaluation, byte-serial result output.
// Nibble and byte order are MSB-first throughout (nibble 0 = bits [63:60]).

module prince_core #(
    parameter int unsigned TEXT_SIZE   = 64,
    parameter int unsigned KEY_SIZE    = 128,
    parameter int unsigned SBOX_NUMBER = 16
) (
    input  logic [TEXT_SIZE-1:0] data_in,
    input  logic [KEY_SIZE-1:0]  key,
    input  logic                 mode,
    output logic [TEXT_SIZE-1:0] data_out
);
    localparam logic [63:0] SBOX_FWD = 64'hBF32AC916780E5D4;
    localparam logic [63:0] SBOX_INV = 64'hB732FD89A6405EC1;
    localparam logic [TEXT_SIZE-1:0] RC [12] = '{
        64'h0000000000000000, 64'h13198a2e03707344, 64'ha4093822299f31d0,
        64'h082efa98ec4e6c89, 64'h452821e638d01377, 64'hbe5466cf34e90c6c,
        64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa, 64'hc882d32f25323c54,
        64'h64a51195e0e3610d, 64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd
    };

    function automatic logic [TEXT_SIZE-1:0] s_layer(input logic [TEXT_SIZE-1:0] x, input logic inv);
        logic [TEXT_SIZE-1:0] y;
        logic [3:0]           n;
        y = x;
        for (int unsigned i = 0; i < SBOX_NUMBER; i++) begin
            n = x[4*i +: 4];
            y[4*i +: 4] = inv ? SBOX_INV[60 - 4*n +: 4] : SBOX_FWD[60 - 4*n +: 4];
        end
        return y;
    endfunction

    // Block (r,c) of M-hat is M_((r+c+h) mod 4); M_k is identity with diagonal entry k cleared.
    function automatic logic [15:0] m_hat(input logic [15:0] x, input int unsigned h);
        logic [15:0] y;
        y = '0;
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++)
                for (int unsigned p = 0; p < 4; p++)
                    if (((r + c + h) % 4) != p)
                        y[15-4*r-p] = y[15-4*r-p] ^ x[15-4*c-p];
        return y;
    endfunction

    function automatic logic [TEXT_SIZE-1:0] m_prime(input logic [TEXT_SIZE-1:0] x);
        return {m_hat(x[63:48], 0), m_hat(x[47:32], 1), m_hat(x[31:16], 1), m_hat(x[15:0], 0)};
    endfunction

    // Forward: out nibble j takes in nibble 5j mod 16; inverse uses 13j (5*13 = 1 mod 16).
    function automatic logic [TEXT_SIZE-1:0] shift_rows(input logic [TEXT_SIZE-1:0] x, input logic inv);
        logic [TEXT_SIZE-1:0] y;
        y = '0;
        for (int unsigned j = 0; j < 16; j++)
            y[TEXT_SIZE-1-4*j -: 4] = x[TEXT_SIZE-1-4*((inv ? 13*j : 5*j) % 16) -: 4];
        return y;
    endfunction

    logic [TEXT_SIZE-1:0] k0, k0p, k1, kc, st;

    // Whole cipher; decryption reuses the datapath via alpha-reflection (swap k0/k0', k1 ^ RC11).
    always_comb begin
        k0  = key[KEY_SIZE-1 -: TEXT_SIZE];
        k1  = key[TEXT_SIZE-1:0];
        k0p = {k0[0], k0[TEXT_SIZE-1:1]} ^ {{(TEXT_SIZE-1){1'b0}}, k0[TEXT_SIZE-1]};
        kc  = mode ? (k1 ^ RC[11]) : k1;
        st  = data_in ^ (mode ? k0p : k0) ^ kc ^ RC[0];
        for (int unsigned r = 1; r <= 5; r++)
            st = shift_rows(m_prime(s_layer(st, 1'b0)), 1'b0) ^ RC[r] ^ kc;
        st = s_layer(m_prime(s_layer(st, 1'b0)), 1'b1);
        for (int unsigned r = 6; r <= 10; r++)
            st = s_layer(m_prime(shift_rows(st ^ kc ^ RC[r], 1'b1)), 1'b1);
        data_out = st ^ RC[11] ^ kc ^ (mode ? k0 : k0p);
    end
endmodule

module prince_byte_stream #(
    parameter int unsigned TEXT_SIZE   = 64,
    parameter int unsigned KEY_SIZE    = 128,
    parameter int unsigned SBOX_NUMBER = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       key_loaded,
    output logic       busy
);
    localparam int unsigned KEY_BYTES  = KEY_SIZE / 8;
    localparam int unsigned TEXT_BYTES = TEXT_SIZE / 8;
    localparam int unsigned MAX_BYTES  = (KEY_BYTES > TEXT_BYTES) ? KEY_BYTES : TEXT_BYTES;
    localparam int unsigned CNT_W      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_BYTES - 1);
    localparam logic [CNT_W-1:0] TEXT_LAST = CNT_W'(TEXT_BYTES - 1);

    typedef enum logic [2:0] {S_HDR, S_KEY, S_TXT, S_CORE, S_OUT} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic [KEY_SIZE-1:0]  key_reg;
    logic [TEXT_SIZE-1:0] text_reg, out_reg, core_out;
    logic                 mode;
    logic                 in_fire, out_fire;

    prince_core #(
        .TEXT_SIZE  (TEXT_SIZE),
        .KEY_SIZE   (KEY_SIZE),
        .SBOX_NUMBER(SBOX_NUMBER)
    ) u_core (
        .data_in (text_reg),
        .key     (key_reg),
        .mode    (mode),
        .data_out(core_out)
    );

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = out_reg[TEXT_SIZE-1 -: 8];
    assign busy     = (state != S_HDR);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_HDR;
        else        state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_HDR: begin
                in_ready = 1'b1;
                if (in_valid) state_next = in_data[1] ? S_KEY : S_TXT;
            end
            S_KEY: begin
                in_ready = 1'b1;
                if (in_valid && cnt == KEY_LAST) state_next = S_TXT;
            end
            S_TXT: begin
                in_ready = 1'b1;
                if (in_valid && cnt == TEXT_LAST) state_next = S_CORE;
            end
            S_CORE: state_next = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready && cnt == TEXT_LAST) state_next = S_HDR;
            end
            default: state_next = S_HDR;
        endcase
    end

    // Datapath: byte counter, key/text shift-in, result capture and shift-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            key_reg    <= '0;
            text_reg   <= '0;
            out_reg    <= '0;
            mode       <= 1'b0;
            key_loaded <= 1'b0;
        end else begin
            case (state)
                S_HDR: if (in_fire) begin
                    mode <= in_data[0];
                    cnt  <= '0;
                end
                S_KEY: if (in_fire) begin
                    key_reg <= {key_reg[KEY_SIZE-9:0], in_data};
                    if (cnt == KEY_LAST) begin
                        key_loaded <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_TXT: if (in_fire) begin
                    text_reg <= {text_reg[TEXT_SIZE-9:0], in_data};
                    cnt      <= (cnt == TEXT_LAST) ? '0 : cnt + 1'b1;
                end
                S_CORE: begin
                    out_reg <= core_out;
                    cnt     <= '0;
                end
                S_OUT: if (out_fire) begin
                    out_reg <= out_reg << 8;
                    cnt     <= (cnt == TEXT_LAST) ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prince_byte_stream.sv
// Scoreboard bench for prince_byte_stream: expected output bytes are queued when
// a frame is driven and compared against the bytes collected from the output port.

module tb_prince_byte_stream;
    logic       clk, rst_n;
    logic [7:0] in_data, out_data;
    logic       in_valid, in_ready, out_valid, out_ready, key_loaded, busy;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]   exp_q[$];
    logic [7:0]   rx_q[$];
    logic [127:0] model_key;
    logic [63:0]  ct1;
    bit           stall_ok, overlap_ok;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [63:0]  TXT_A = 64'h0102030405060708;
    localparam logic [127:0] KEY_B = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [63:0]  TXT_B = 64'hDEADBEEFCAFEF00D;

    localparam logic [63:0] SBF = 64'hBF32AC916780E5D4;
    localparam logic [63:0] SBI = 64'hB732FD89A6405EC1;
    localparam logic [15:0] MH0 [16] = '{
        16'h0111, 16'h2220, 16'h4404, 16'h8088, 16'h1011, 16'h0222, 16'h4440, 16'h8808,
        16'h1101, 16'h2022, 16'h0444, 16'h8880, 16'h1110, 16'h2202, 16'h4044, 16'h0888
    };
    localparam logic [63:0] RC [12] = '{
        64'h0000000000000000, 64'h13198a2e03707344, 64'ha4093822299f31d0,
        64'h082efa98ec4e6c89, 64'h452821e638d01377, 64'hbe5466cf34e90c6c,
        64'h7ef84f78fd955cb1, 64'h85840851f1ac43aa, 64'hc882d32f25323c54,
        64'h64a51195e0e3610d, 64'hd3b5a399ca0c2399, 64'hc0ac29b7c97c50dd
    };

    prince_byte_stream #(
        .TEXT_SIZE  (64),
        .KEY_SIZE   (128),
        .SBOX_NUMBER(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .key_loaded(key_loaded),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1);
    end

    // ---------------- reference model (column-table M', rotate-based rows) ----------------
    function automatic logic [63:0] tb_sbox(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        int          n;
        for (int i = 0; i < 16; i++) begin
            n = int'(x[4*i +: 4]);
            y[4*i +: 4] = inv ? SBI[60 - 4*n +: 4] : SBF[60 - 4*n +: 4];
        end
        return y;
    endfunction

    function automatic logic [15:0] tb_mhat(input logic [15:0] x, input bit one);
        logic [15:0] y = '0;
        for (int i = 0; i < 16; i++)
            if (x[i]) y = y ^ (one ? MH0[(i + 12) % 16] : MH0[i]);
        return y;
    endfunction

    function automatic logic [63:0] tb_mp(input logic [63:0] x);
        return {tb_mhat(x[63:48], 0), tb_mhat(x[47:32], 1), tb_mhat(x[31:16], 1), tb_mhat(x[15:0], 0)};
    endfunction

    function automatic logic [63:0] tb_sr(input logic [63:0] x, input bit inv);
        logic [63:0] y = '0;
        logic [63:0] row;
        int          s;
        for (int i = 0; i < 4; i++) begin
            row = x & (64'hF000F000F000F000 >> (4*i));
            s   = 16*i;
            if (!inv) y = y | (row << s) | (row >> (64 - s));
            else      y = y | (row >> s) | (row << (64 - s));
        end
        return y;
    endfunction

    function automatic logic [63:0] tb_prince(input logic [63:0] pt, input logic [127:0] k, input bit dec);
        logic [63:0] k0, k0p, k1, t, s;
        k0  = k[127:64];
        k1  = k[63:0];
        k0p = {k0[0], k0[63:1]} ^ (k0 >> 63);
        if (dec) begin
            t = k0; k0 = k0p; k0p = t;
            k1 = k1 ^ RC[11];
        end
        s = pt ^ k0 ^ k1 ^ RC[0];
        for (int r = 1; r <= 5; r++) begin
            s = tb_sr(tb_mp(tb_sbox(s, 0)), 0);
            s = s ^ RC[r] ^ k1;
        end
        s = tb_sbox(tb_mp(tb_sbox(s, 0)), 1);
        for (int r = 6; r <= 10; r++) begin
            s = s ^ k1 ^ RC[r];
            s = tb_sbox(tb_mp(tb_sr(s, 1)), 1);
        end
        return s ^ RC[11] ^ k1 ^ k0p;
    endfunction

    // ---------------- stimulus / collection ----------------
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            n = 0;
            while ($urandom_range(0, 1) == 0 && n < 6) begin
                in_valid = 1'b0;
                @(negedge clk);
                n++;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            compared++;
            mismatched++;
            $display("FAIL in_ready_timeout: got in_ready=%b, want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [127:0] k, input logic [63:0] txt,
                              input bit gaps, input bit use_exp, input logic [63:0] exp_val);
        logic [63:0] e;
        if (hdr[1]) model_key = k;
        e = use_exp ? exp_val : tb_prince(txt, model_key, hdr[0]);
        for (int i = 7; i >= 0; i--) exp_q.push_back(e[8*i +: 8]);
        send_byte(hdr, gaps);
        if (hdr[1]) for (int i = 15; i >= 0; i--) send_byte(k[8*i +: 8], gaps);
        for (int i = 7; i >= 0; i--) send_byte(txt[8*i +: 8], gaps);
    endtask

    task automatic collect(input int nbytes, input int stall_at);
        int         waited = 0;
        logic [7:0] held;
        rx_q.delete();
        stall_ok   = 1'b1;
        overlap_ok = 1'b1;
        out_ready  = 1'b1;
        while (rx_q.size() < nbytes && waited < 200) begin
            if (out_valid === 1'b1 && in_ready === 1'b1) overlap_ok = 1'b0;
            if (stall_at >= 0 && rx_q.size() == stall_at && out_valid === 1'b1) begin
                out_ready = 1'b0;
                held = out_data;
                repeat (5) begin
                    @(negedge clk);
                    if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stall_ok = 1'b0;
                end
                out_ready = 1'b1;
                stall_at  = -1;
            end
            if (out_valid === 1'b1) rx_q.push_back(out_data);
            @(negedge clk);
            waited++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if ({in_ready, out_valid, busy, key_loaded} !== 4'b1000) begin
            mismatched++;
            $display("FAIL reset_flags: got rdy/vld/busy/kl=%b, want 1000", {in_ready, out_valid, busy, key_loaded});
        end
        compared++;
        if (out_data !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_out_data: got %02h, want 00", out_data);
        end
        rst_n = 1'b1;
        model_key = '0;
        @(negedge clk);
    endtask

    task automatic test_nokey_zero();
        logic [7:0] e;
        send_frame(8'h00, '0, 64'hFFFFFFFFFFFFFFFF, 0, 1, 64'h604ae6ca03c20ada);
        collect(8, -1);
        compared++;
        if (rx_q.size() != 8) begin
            mismatched++;
            $display("FAIL zero_key_count: got %0d bytes, want 8", rx_q.size());
        end
        for (int i = 0; i < rx_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            compared++;
            if (rx_q[i] !== e) begin
                mismatched++;
                $display("FAIL zero_key_byte%0d: got %02h, want %02h", i, rx_q[i], e);
            end
        end
        exp_q.delete();
        compared++;
        if (key_loaded !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_key_loaded: got %b, want 0", key_loaded);
        end
    endtask

    task automatic test_key_enc();
        logic [7:0] e;
        ct1 = tb_prince(TXT_A, KEY_A, 0);
        send_frame(8'h02, KEY_A, TXT_A, 0, 0, '0);
        compared++;
        if ({out_valid, in_ready, busy} !== 3'b001) begin
            mismatched++;
            $display("FAIL core_cycle: got vld/rdy/busy=%b, want 001", {out_valid, in_ready, busy});
        end
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL latency: got out_valid=%b, want 1", out_valid);
        end
        collect(8, -1);
        compared++;
        if (rx_q.size() != 8) begin
            mismatched++;
            $display("FAIL enc_count: got %0d bytes, want 8", rx_q.size());
        end
        for (int i = 0; i < rx_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            compared++;
            if (rx_q[i] !== e) begin
                mismatched++;
                $display("FAIL enc_byte%0d: got %02h, want %02h", i, rx_q[i], e);
            end
        end
        exp_q.delete();
        compared++;
        if (key_loaded !== 1'b1) begin
            mismatched++;
            $display("FAIL enc_key_loaded: got %b, want 1", key_loaded);
        end
    endtask

    task automatic test_decrypt();
        logic [7:0] e;
        send_frame(8'h01, '0, ct1, 0, 1, TXT_A);
        collect(8, -1);
        compared++;
        if (rx_q.size() != 8) begin
            mismatched++;
            $display("FAIL dec_count: got %0d bytes, want 8", rx_q.size());
        end
        for (int i = 0; i < rx_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            compared++;
            if (rx_q[i] !== e) begin
                mismatched++;
                $display("FAIL dec_byte%0d: got %02h, want %02h", i, rx_q[i], e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_stalls();
        logic [7:0] e;
        send_frame(8'h00, '0, TXT_A, 1, 1, ct1);
        collect(8, 3);
        compared++;
        if (rx_q.size() != 8) begin
            mismatched++;
            $display("FAIL stall_count: got %0d bytes, want 8", rx_q.size());
        end
        for (int i = 0; i < rx_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            compared++;
            if (rx_q[i] !== e) begin
                mismatched++;
                $display("FAIL stall_byte%0d: got %02h, want %02h", i, rx_q[i], e);
            end
        end
        exp_q.delete();
        compared++;
        if (stall_ok !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_hold: got stable=%b, want 1", stall_ok);
        end
        compared++;
        if (overlap_ok !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_valid_overlap: got exclusive=%b, want 1", overlap_ok);
        end
    endtask

    task automatic test_reserved_hdr();
        logic [7:0] e;
        send_frame(8'hFE, KEY_A, TXT_A, 0, 1, ct1);
        collect(8, -1);
        compared++;
        if (rx_q.size() != 8) begin
            mismatched++;
            $display("FAIL rsvd_count: got %0d bytes, want 8", rx_q.size());
        end
        for (int i = 0; i < rx_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            compared++;
            if (rx_q[i] !== e) begin
                mismatched++;
                $display("FAIL rsvd_byte%0d: got %02h, want %02h", i, rx_q[i], e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        send_frame(8'h02, {64'h0, 64'hfedcba9876543210}, 64'h0123456789abcdef, 0, 1, 64'hae25ad3ca8fa9ccf);
        collect(8, -1);
        compared++;
        if ({in_ready, busy} !== 2'b10) begin
            mismatched++;
            $display("FAIL turnaround: got rdy/busy=%b, want 10", {in_ready, busy});
        end
        send_frame(8'h01, '0, 64'hae25ad3ca8fa9ccf, 0, 1, 64'h0123456789abcdef);
        collect(8, -1);
        compared++;
        if (rx_q.size() != 8) begin
            mismatched++;
            $display("FAIL b2b_count: got %0d bytes, want 8", rx_q.size());
        end
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            compared++;
            if (i >= 8 || rx_q.size() != 8) begin
                mismatched++;
                $display("FAIL b2b_enc_byte%0d: got missing byte, want %02h", i, e);
            end
        end
        for (int i = 0; i < rx_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            compared++;
            if (rx_q[i] !== e) begin
                mismatched++;
                $display("FAIL b2b_dec_byte%0d: got %02h, want %02h", i, rx_q[i], e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_partial_reset();
        logic [7:0] e;
        send_byte(8'h02, 0);
        for (int i = 0; i < 7; i++) send_byte(8'hA0 + 8'(i), 0);
        rst_n = 1'b0;
        #1;
        compared++;
        if ({in_ready, busy, key_loaded, out_valid} !== 4'b1000) begin
            mismatched++;
            $display("FAIL async_reset: got rdy/busy/kl/vld=%b, want 1000", {in_ready, busy, key_loaded, out_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_key = '0;
        exp_q.delete();
        @(negedge clk);
        send_frame(8'h00, '0, 64'hFFFFFFFFFFFFFFFF, 0, 1, 64'h604ae6ca03c20ada);
        send_frame(8'h02, KEY_B, TXT_B, 0, 0, '0);
        compared++;
        if (exp_q.size() != 16) begin
            mismatched++;
            $display("FAIL prst_queue: got %0d expected bytes, want 16", exp_q.size());
        end
        // first frame's 8 bytes were produced before the second frame was sent
        exp_q = exp_q[8:$];
        collect(8, -1);
        for (int i = 0; i < rx_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            compared++;
            if (rx_q[i] !== e) begin
                mismatched++;
                $display("FAIL prst_byte%0d: got %02h, want %02h", i, rx_q[i], e);
            end
        end
        compared++;
        if (rx_q.size() != 8) begin
            mismatched++;
            $display("FAIL prst_count: got %0d bytes, want 8", rx_q.size());
        end
        exp_q.delete();
        compared++;
        if (key_loaded !== 1'b1) begin
            mismatched++;
            $display("FAIL prst_key_loaded: got %b, want 1", key_loaded);
        end
    endtask

    task automatic test_partial_reset_zero_key();
        logic [7:0] e;
        send_byte(8'h02, 0);
        for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i), 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_key = '0;
        @(negedge clk);
        send_frame(8'h00, '0, 64'hFFFFFFFFFFFFFFFF, 0, 1, 64'h604ae6ca03c20ada);
        collect(8, -1);
        compared++;
        if (rx_q.size() != 8) begin
            mismatched++;
            $display("FAIL prst_zero_count: got %0d bytes, want 8", rx_q.size());
        end
        for (int i = 0; i < rx_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            compared++;
            if (rx_q[i] !== e) begin
                mismatched++;
                $display("FAIL prst_zero_byte%0d: got %02h, want %02h", i, rx_q[i], e);
            end
        end
        exp_q.delete();
        compared++;
        if (key_loaded !== 1'b0) begin
            mismatched++;
            $display("FAIL prst_zero_key_loaded: got %b, want 0", key_loaded);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        model_key = '0;
        @(negedge clk);
        test_reset();
        test_nokey_zero();
        test_key_enc();
        test_decrypt();
        test_stalls();
        test_reserved_hdr();
        test_back_to_back();
        test_partial_reset_zero_key();
        test_partial_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
